// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle for the sequential ALU.
//   master (requester): drives start, op, a, b, c_in; observes ready, y, flags, done, illegal
//   slave  (alu_seq)  : the mirror image
// flags is packed {C, V, N, Z}.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [WIDTH-1:0] y;
  logic [3:0]       flags;
  logic             done;
  logic             illegal;

  modport master (
    output start, op, a, b, c_in,
    input  ready, y, flags, done, illegal
  );

  modport slave (
    input  start, op, a, b, c_in,
    output ready, y, flags, done, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with start/ready/done handshake.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any running op, no done)
//   bus  : alu_seq_if.slave
//     start/ready : request accepted on an edge where start && ready
//     op, a, b    : opcode and operands; b[SW-1:0] is the shift amount
//     c_in        : carry in for PASS/ADD/SUB
//     y, flags    : registered result and {C, V, N, Z}, held until next completion
//     done        : one-cycle pulse after y/flags update
//     illegal     : reserved, always 0 (every 4-bit opcode is defined)
// Single-cycle ops register their result at the accepting edge. Shifts with
// n>=1 run one bit per edge for n edges; MUL runs WIDTH shift-add steps.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  localparam logic [3:0] OP_PASS = 4'd0,  OP_ADD  = 4'd1,  OP_SUB  = 4'd2,  OP_DEC  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR  = 4'd6,  OP_NOTA = 4'd7;
  localparam logic [3:0] OP_NOTB = 4'd8,  OP_XNOR = 4'd9,  OP_SHL  = 4'd10, OP_SHR  = 4'd11;
  localparam logic [3:0] OP_ASR  = 4'd12, OP_ROL  = 4'd13, OP_MUL  = 4'd14, OP_CLR  = 4'd15;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] work_reg;    // shift data, or multiplier / low product half
  logic [WIDTH-1:0] mcand_reg;   // multiplicand
  logic [WIDTH-1:0] acc_hi_reg;  // high product half
  logic [SW:0]      count_reg;   // steps remaining, up to WIDTH
  logic [WIDTH-1:0] y_reg;
  logic [3:0]       flags_reg;
  logic             done_reg;
  logic             ready_reg;
  logic             illegal_reg;

  logic [SW-1:0]    n_amt;
  logic             is_shift;
  logic             multi_cycle;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] sc_y;
  logic             sc_c;
  logic             sc_v;

  assign n_amt       = bus.b[SW-1:0];
  assign is_shift    = (bus.op == OP_SHL) || (bus.op == OP_SHR) ||
                       (bus.op == OP_ASR) || (bus.op == OP_ROL);
  assign multi_cycle = (bus.op == OP_MUL) || (is_shift && (n_amt != '0));

  // Single-cycle result from the live inputs. Shift ops only reach this path
  // with n=0, where the result is a unchanged and C=0.
  always_comb begin
    ext  = '0;
    sc_y = '0;
    sc_c = 1'b0;
    sc_v = 1'b0;
    case (bus.op)
      OP_PASS: begin
        ext  = {1'b0, bus.a} + (WIDTH+1)'(bus.c_in);
        sc_y = ext[WIDTH-1:0];
        sc_c = ext[WIDTH];
      end
      OP_ADD: begin
        ext  = {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH+1)'(bus.c_in);
        sc_y = ext[WIDTH-1:0];
        sc_c = ext[WIDTH];
        sc_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        ext  = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(bus.c_in);
        sc_y = ext[WIDTH-1:0];
        sc_c = ext[WIDTH];
        sc_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_DEC: begin
        sc_y = bus.a - WIDTH'(1);
        sc_c = |bus.a;  // carry means "no borrow"
      end
      OP_AND:  sc_y = bus.a & bus.b;
      OP_OR:   sc_y = bus.a | bus.b;
      OP_XOR:  sc_y = bus.a ^ bus.b;
      OP_NOTA: sc_y = ~bus.a;
      OP_NOTB: sc_y = ~bus.b;
      OP_XNOR: sc_y = ~(bus.a ^ bus.b);
      OP_SHL, OP_SHR, OP_ASR, OP_ROL: sc_y = bus.a;
      default: sc_y = '0;  // CLR (MUL never takes this path)
    endcase
  end

  // One step of the running multi-cycle op.
  logic [WIDTH-1:0] step_y;
  logic             step_c;
  logic [WIDTH-1:0] acc_hi_next;
  logic [WIDTH:0]   mul_sum;

  always_comb begin
    step_y      = work_reg;
    step_c      = 1'b0;
    acc_hi_next = acc_hi_reg;
    mul_sum     = {1'b0, acc_hi_reg} + (work_reg[0] ? {1'b0, mcand_reg} : '0);
    case (op_reg)
      OP_SHL: begin
        step_y = {work_reg[WIDTH-2:0], 1'b0};
        step_c = work_reg[WIDTH-1];
      end
      OP_SHR: begin
        step_y = {1'b0, work_reg[WIDTH-1:1]};
        step_c = work_reg[0];
      end
      OP_ASR: begin
        step_y = {work_reg[WIDTH-1], work_reg[WIDTH-1:1]};
        step_c = work_reg[0];
      end
      OP_ROL: begin
        step_y = {work_reg[WIDTH-2:0], work_reg[WIDTH-1]};
        step_c = work_reg[WIDTH-1];
      end
      OP_MUL: begin
        // Conditional add of the multiplicand into the high half, then shift
        // the whole {carry, hi, lo} right; after WIDTH steps {hi, lo} = a*b.
        acc_hi_next = mul_sum[WIDTH:1];
        step_y      = {mul_sum[0], work_reg[WIDTH-1:1]};
        step_c      = |mul_sum[WIDTH:1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      op_reg      <= OP_PASS;
      work_reg    <= '0;
      mcand_reg   <= '0;
      acc_hi_reg  <= '0;
      count_reg   <= '0;
      y_reg       <= '0;
      flags_reg   <= 4'b0000;
      done_reg    <= 1'b0;
      ready_reg   <= 1'b1;
      illegal_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start && ready_reg) begin
            if (multi_cycle) begin
              op_reg     <= bus.op;
              acc_hi_reg <= '0;
              if (bus.op == OP_MUL) begin
                work_reg  <= bus.b;
                mcand_reg <= bus.a;
                count_reg <= (SW+1)'(WIDTH);
              end else begin
                work_reg  <= bus.a;
                mcand_reg <= '0;
                count_reg <= {1'b0, n_amt};
              end
              state_reg <= BUSY;
              ready_reg <= 1'b0;
            end else begin
              y_reg       <= sc_y;
              flags_reg   <= {sc_c, sc_v, sc_y[WIDTH-1], ~|sc_y};
              done_reg    <= 1'b1;
              illegal_reg <= 1'b0;
            end
          end
        end
        BUSY: begin
          work_reg   <= step_y;
          acc_hi_reg <= acc_hi_next;
          count_reg  <= count_reg - (SW+1)'(1);
          if (count_reg == (SW+1)'(1)) begin
            y_reg       <= step_y;
            flags_reg   <= {step_c, 1'b0, step_y[WIDTH-1], ~|step_y};
            done_reg    <= 1'b1;
            illegal_reg <= 1'b0;
            state_reg   <= IDLE;
            ready_reg   <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ready   = ready_reg;
  assign bus.y       = y_reg;
  assign bus.flags   = flags_reg;
  assign bus.done    = done_reg;
  assign bus.illegal = illegal_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=8). Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge.
module tb_alu_seq;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Issue one op and wait for its done. lat = edges after the accepting edge
  // until done is seen (0 for single-cycle ops), -1 on timeout.
  // low = number of waiting samples with ready low.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, output int lat, output int low);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.c_in = cin;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; low = 0;
    while (!bus.done && lat < 20) begin
      if (!bus.ready) low++;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.done) lat = -1;
    $display("op=%0d a=%02h b=%02h cin=%0d -> y=%02h flags=%04b lat=%0d", op, a, b, cin, bus.y, bus.flags, lat);
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.op = 4'd0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.y !== 8'h00 || bus.flags !== 4'b0000 || bus.done !== 1'b0 ||
        bus.illegal !== 1'b0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: y=%02h flags=%04b done=%b illegal=%b ready=%b, want 00 0000 0 0 1",
               bus.y, bus.flags, bus.done, bus.illegal, bus.ready);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add;
    int lat, low;
    run_op(4'd1, 8'hFF, 8'h01, 1'b0, lat, low);
    checks++;
    if (lat !== 0 || bus.y !== 8'h00 || bus.flags !== 4'b1001 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL add_ff_01: lat=%0d y=%02h flags=%04b ready=%b, want 0 00 1001 1", lat, bus.y, bus.flags, bus.ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL add_done_pulse: done=%b, want 0", bus.done);
    end
  endtask

  task automatic test_sub_dec;
    int lat, low;
    run_op(4'd2, 8'h80, 8'h01, 1'b1, lat, low);
    checks++;
    if (lat !== 0 || bus.y !== 8'h7F || bus.flags !== 4'b1100) begin
      errors++;
      $display("FAIL sub_80_01: lat=%0d y=%02h flags=%04b, want 0 7f 1100", lat, bus.y, bus.flags);
    end
    run_op(4'd3, 8'h00, 8'h00, 1'b0, lat, low);
    checks++;
    if (lat !== 0 || bus.y !== 8'hFF || bus.flags !== 4'b0010) begin
      errors++;
      $display("FAIL dec_00: lat=%0d y=%02h flags=%04b, want 0 ff 0010", lat, bus.y, bus.flags);
    end
  endtask

  task automatic test_shifts;
    int lat, low;
    run_op(4'd10, 8'h81, 8'h03, 1'b0, lat, low);
    checks++;
    if (lat !== 3 || low !== 3 || bus.y !== 8'h08 || bus.flags !== 4'b0000 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL shl_81_3: lat=%0d low=%0d y=%02h flags=%04b ready=%b, want 3 3 08 0000 1",
               lat, low, bus.y, bus.flags, bus.ready);
    end
    run_op(4'd12, 8'h81, 8'h01, 1'b0, lat, low);
    checks++;
    if (lat !== 1 || bus.y !== 8'hC0 || bus.flags !== 4'b1010) begin
      errors++;
      $display("FAIL asr_81_1: lat=%0d y=%02h flags=%04b, want 1 c0 1010", lat, bus.y, bus.flags);
    end
    run_op(4'd13, 8'h81, 8'h01, 1'b0, lat, low);
    checks++;
    if (lat !== 1 || bus.y !== 8'h03 || bus.flags !== 4'b1000) begin
      errors++;
      $display("FAIL rol_81_1: lat=%0d y=%02h flags=%04b, want 1 03 1000", lat, bus.y, bus.flags);
    end
    run_op(4'd13, 8'h81, 8'h07, 1'b0, lat, low);
    checks++;
    if (lat !== 7 || bus.y !== 8'hC0 || bus.flags !== 4'b0010) begin
      errors++;
      $display("FAIL rol_81_7: lat=%0d y=%02h flags=%04b, want 7 c0 0010", lat, bus.y, bus.flags);
    end
    run_op(4'd11, 8'hA5, 8'h00, 1'b0, lat, low);
    checks++;
    if (lat !== 0 || low !== 0 || bus.y !== 8'hA5 || bus.flags !== 4'b0010) begin
      errors++;
      $display("FAIL shr_n0: lat=%0d low=%0d y=%02h flags=%04b, want 0 0 a5 0010", lat, low, bus.y, bus.flags);
    end
  endtask

  task automatic test_mul_zero;
    int lat, low;
    run_op(4'd14, 8'h5A, 8'h00, 1'b0, lat, low);
    checks++;
    if (lat !== 8 || bus.y !== 8'h00 || bus.flags !== 4'b0001) begin
      errors++;
      $display("FAIL mul_by_0: lat=%0d y=%02h flags=%04b, want 8 00 0001", lat, bus.y, bus.flags);
    end
  endtask

  task automatic test_mul_ignore_start;
    int dcnt = 0;
    int first = -1;
    logic [7:0] y_at;
    logic [3:0] f_at;
    logic ready_mid;
    y_at = 8'hXX; f_at = 4'hX; ready_mid = 1'bX;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd14; bus.a = 8'h10; bus.b = 8'h11; bus.c_in = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 4) begin
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd1; bus.a = 8'h01; bus.b = 8'h01;
      end
      @(posedge clk); #1;
      if (i == 4) begin
        bus.start = 1'b0;
        ready_mid = bus.ready;
      end
      if (bus.done) begin
        dcnt++;
        if (first < 0) begin
          first = i; y_at = bus.y; f_at = bus.flags;
        end
      end
    end
    $display("mul a=10 b=11 with ADD start at step 4 -> dones=%0d first=%0d y=%02h flags=%04b", dcnt, first, y_at, f_at);
    checks++;
    if (dcnt !== 1 || first !== 8 || ready_mid !== 1'b0) begin
      errors++;
      $display("FAIL mul_done_count: dones=%0d first=%0d ready_mid=%b, want 1 8 0", dcnt, first, ready_mid);
    end
    checks++;
    if (y_at !== 8'h10 || f_at !== 4'b1000 || bus.y !== 8'h10) begin
      errors++;
      $display("FAIL mul_10_11: y=%02h flags=%04b y_end=%02h, want 10 1000 10", y_at, f_at, bus.y);
    end
  endtask

  task automatic test_reset_mid_busy;
    int dcnt = 0;
    int lat, low;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd14; bus.a = 8'h0F; bus.b = 8'h0F; bus.c_in = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    $display("mul a=0f b=0f reset at accept+4 -> y=%02h flags=%04b ready=%b done=%b", bus.y, bus.flags, bus.ready, bus.done);
    checks++;
    if (bus.y !== 8'h00 || bus.flags !== 4'b0000 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: y=%02h flags=%04b ready=%b done=%b, want 00 0000 1 0",
               bus.y, bus.flags, bus.ready, bus.done);
    end
    @(negedge clk); rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
    end
    checks++;
    if (dcnt !== 0) begin
      errors++;
      $display("FAIL reset_abort_no_done: dones=%0d, want 0", dcnt);
    end
    run_op(4'd1, 8'h02, 8'h03, 1'b0, lat, low);
    checks++;
    if (lat !== 0 || bus.y !== 8'h05 || bus.flags !== 4'b0000) begin
      errors++;
      $display("FAIL add_after_reset: lat=%0d y=%02h flags=%04b, want 0 05 0000", lat, bus.y, bus.flags);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd6; bus.a = 8'hF0; bus.b = 8'hFF; bus.c_in = 1'b0;
    @(posedge clk); #1;
    $display("b2b XOR  -> y=%02h flags=%04b done=%b", bus.y, bus.flags, bus.done);
    checks++;
    if (bus.y !== 8'h0F || bus.flags !== 4'b0000 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_xor: y=%02h flags=%04b done=%b, want 0f 0000 1", bus.y, bus.flags, bus.done);
    end
    @(negedge clk);
    bus.op = 4'd8; bus.b = 8'h0F;
    @(posedge clk); #1;
    $display("b2b NOTB -> y=%02h flags=%04b done=%b", bus.y, bus.flags, bus.done);
    checks++;
    if (bus.y !== 8'hF0 || bus.flags !== 4'b0010 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_notb: y=%02h flags=%04b done=%b, want f0 0010 1", bus.y, bus.flags, bus.done);
    end
    @(negedge clk);
    bus.op = 4'd15;
    @(posedge clk); #1;
    $display("b2b CLR  -> y=%02h flags=%04b done=%b", bus.y, bus.flags, bus.done);
    checks++;
    if (bus.y !== 8'h00 || bus.flags !== 4'b0001 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_clr: y=%02h flags=%04b done=%b, want 00 0001 1", bus.y, bus.flags, bus.done);
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_done: done=%b, want 0", bus.done);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_dec;
    test_shifts;
    test_mul_zero;
    test_mul_ignore_start;
    test_reset_mid_busy;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU: the registered, multi-cycle successor to the team's combinational 4-bit arithmetic unit. It adds:
- a start/ready/done handshake;
- status flags (carry, zero, negative, overflow);
- variable-amount shifts and rotate, executed one bit per cycle;
- an iterative shift-add multiplier.

It sits between the datapath register file and the result bus. Single-cycle ops sustain one result per clock.

## Interface
Parameters:
- WIDTH, 8, operand/result width (≥2, power of 2)
- SW, $clog2(WIDTH), shift-amount width (derived)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted on an edge where start && ready
- ready  out  1  unit can accept; low while a multi-cycle op runs
- op  in  4  operation code (below)
- a, b  in  WIDTH  operands; b[SW-1:0] is shift amount n for shift ops
- c_in  in  1  carry in
- y  out  WIDTH  registered result, held until next completion
- flags  out  4  {C, V, N, Z}, registered with y
- done  out  1  one-cycle pulse: y/flags just updated
- illegal  out  1  registered with y; 1 if completed op was undefined

## Operation
Opcodes:
- 0 PASS: a+c_in
- 1 ADD: a+b+c_in
- 2 SUB: a+~b+c_in (c_in=1 gives a−b)
- 3 DEC: a−1
- 4 AND
- 5 OR
- 6 XOR
- 7 NOTA
- 8 NOTB
- 9 XNOR
- 10 SHL n
- 11 SHR n (logical)
- 12 ASR n
- 13 ROL n
- 14 MUL (low WIDTH bits of a*b, unsigned)
- 15 CLR: y=0

Arithmetic:
- Ops 0–3 evaluated at WIDTH+1 bits.
- C = bit WIDTH (DEC: C=1 iff a≠0, i.e. no borrow).
- V = signed overflow for ADD/SUB; 0 for PASS/DEC.

Flags by op class:
- Logic ops and CLR: C=V=0.
- Shifts/rotate: C = last bit shifted out (ROL: last bit wrapped); C=0 when n=0; V=0.
- MUL: C=1 iff upper WIDTH bits of the 2·WIDTH-bit product ≠0; V=0.
- All ops: Z=(y==0), N=y[WIDTH-1].

Op codes above 15 cannot occur with a 4-bit op port. `illegal` is reserved and stays 0. It is kept for a future wider opcode.

FSM states:
- IDLE: ready=1.
- On accept of a single-cycle op (0–9, 15, or shift/rotate with n=0): compute from the live inputs and register y/flags at the accepting edge; stay in IDLE.
- On accept of a multi-cycle op: capture a, b, op and count (n or WIDTH) into internal registers; go to BUSY; ready=0.
- BUSY: one shift step (or one multiply add/shift step) per edge; count decrements.
- When the final step registers y/flags, return to IDLE.
- start, a, b, op and c_in are ignored throughout BUSY.

Boundary conditions:
- n=WIDTH−1 is the maximum shift; n is never ≥WIDTH (truncated to SW bits).
- ASR replicates a[WIDTH-1].
- ROL by n is a rotation; y equals a rotated n places, no data lost.
- MUL of any value by 0 → y=0, Z=1, C=0.
- rst in any state, including mid-BUSY:
  - the op is aborted with no done;
  - next cycle: state IDLE, y=0, flags=0, done=0, illegal=0, ready=1.

## Timing
Reset values: y=0, flags=4'b0000, done=0, illegal=0, ready=1.

Latency by op class (accept edge k):
- Single-cycle op: result registered at k; done=1 during cycle k→k+1; ready stays 1, so back-to-back accepts are allowed every edge.
- Shift/rotate with n≥1: ready=0 after k; result registered at edge k+n; done=1 and ready=1 in the cycle after k+n.
- MUL: same rule with n=WIDTH.

Handshake:
- A new start may be accepted on the same edge that follows done; there is no dead cycle.
- done is never high for two consecutive cycles from a single op.
- Consecutive single-cycle ops each produce their own one-cycle done, which may appear high across consecutive cycles.

## Test plan (WIDTH=8)
- ADD a=FF, b=01, c_in=0 → y=00, C=1, Z=1, V=0; done the cycle after accept; ready stays 1.
- SUB a=80, b=01, c_in=1 → y=7F, C=1, V=1, N=0. Then DEC a=00 → y=FF, C=0, N=1.
- SHL a=81, b=03 → ready low 3 cycles; y=08, C=0. ASR a=81, b=01 → y=C0, C=1. ROL a=81, b=01 → y=03, C=1.
- MUL a=10, b=11 → done 8 cycles after accept; y=10, C=1. A start pulse with op=ADD mid-op is ignored: exactly one done, y=10.
- MUL a=0F, b=0F, rst asserted 4 cycles after accept → no done; the cycle after reset: y=00, flags=0000, ready=1. Then ADD a=02, b=03 → y=05.
- Back-to-back: XOR (a=F0, b=FF) then NOTB (b=0F) then CLR on consecutive edges → y=0F, F0, 00 on consecutive cycles; done high three cycles; Z=1 on the last.
